// File: rtl/des_pkg.sv
// Shared DES round constants, controller state encoding and S-box lookup helpers.
package des_pkg;

    localparam int unsigned NUM_BOX   = 8;
    localparam int unsigned SB_IN_W   = 6;
    localparam int unsigned SB_OUT_W  = 4;
    localparam int unsigned BLK_IN_W  = 48;
    localparam int unsigned BLK_OUT_W = 32;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned TBL_W     = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Six-bit group k of a round value; group 0 is the most significant.
    function automatic logic [SB_IN_W-1:0] get_group(input logic [BLK_IN_W-1:0] data,
                                                     input logic [IDX_W-1:0]    idx);
        logic [SB_IN_W-1:0] g;
        g = '0;
        for (int unsigned k = 0; k < NUM_BOX; k++) begin
            if (idx == IDX_W'(k)) begin
                g = data[BLK_IN_W-1-SB_IN_W*k -: SB_IN_W];
            end
        end
        return g;
    endfunction

    // Replace nibble k of a result word; nibble 0 is the most significant.
    function automatic logic [BLK_OUT_W-1:0] set_nibble(input logic [BLK_OUT_W-1:0] word,
                                                        input logic [IDX_W-1:0]     idx,
                                                        input logic [SB_OUT_W-1:0]  nib);
        logic [BLK_OUT_W-1:0] w;
        w = word;
        for (int unsigned k = 0; k < NUM_BOX; k++) begin
            if (idx == IDX_W'(k)) begin
                w[BLK_OUT_W-1-SB_OUT_W*k -: SB_OUT_W] = nib;
            end
        end
        return w;
    endfunction

    // S1..S8 tables, 64 nibbles each, entry row*16+col stored most-significant first.
    function automatic logic [SB_OUT_W-1:0] sbox_lookup(input logic [IDX_W-1:0]   box,
                                                        input logic [SB_IN_W-1:0] x);
        logic [TBL_W-1:0] tbl;
        logic [5:0]       pos;
        logic [9:0]       sh;
        case (box)
            3'd0:    tbl = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
            3'd1:    tbl = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
            3'd2:    tbl = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
            3'd3:    tbl = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
            3'd4:    tbl = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
            3'd5:    tbl = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
            3'd6:    tbl = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
            default: tbl = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
        endcase
        // Row from the outer bits, column from the inner four.
        pos = {x[5], x[0], x[4:1]};
        sh  = 10'(TBL_W - SB_OUT_W) - {2'b00, pos, 2'b00};
        return SB_OUT_W'(tbl >> sh);
    endfunction

endpackage

// File: rtl/sbox_bank.sv
// Combinational S1..S8 bank muxed by box index; lives beside the sequencer in the round.
module sbox_bank
    import des_pkg::*;
(
    input  logic [IDX_W-1:0]    sbox_sel,
    input  logic [SB_IN_W-1:0]  sbox_in,
    output logic [SB_OUT_W-1:0] sbox_out_c
);

    logic [SB_OUT_W-1:0] box_out [NUM_BOX];

    for (genvar g = 0; g < NUM_BOX; g++) begin : g_box
        // One S-box evaluated on the shared raw group.
        always_comb begin
            box_out[g] = sbox_lookup(IDX_W'(g), sbox_in);
        end
    end

    // Select the addressed box.
    always_comb begin
        sbox_out_c = box_out[sbox_sel];
    end

endmodule

// File: rtl/sbox_round_sequencer.sv
// Sequences the eight six-bit groups of a round value through one shared S-box port.
module sbox_round_sequencer
    import des_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLK_IN_W-1:0]   in_data,
    output logic [IDX_W-1:0]      sbox_sel,
    output logic [SB_IN_W-1:0]    sbox_in,
    input  logic [SB_OUT_W-1:0]   sbox_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLK_OUT_W-1:0]  out_data,
    output logic                  busy
);

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [BLK_IN_W-1:0]  data_reg, data_next;
    logic [BLK_OUT_W-1:0] result, result_next;

    logic                 in_ready_next;
    logic [IDX_W-1:0]     sbox_sel_next;
    logic [SB_IN_W-1:0]   sbox_in_next;
    logic                 out_valid_next;
    logic [BLK_OUT_W-1:0] out_data_next;
    logic                 busy_next;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        data_next   = data_reg;
        result_next = result;

        if (abort) begin
            state_next  = ST_IDLE;
            idx_next    = '0;
            data_next   = '0;
            result_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_next  = ST_RUN;
                        idx_next    = '0;
                        data_next   = in_data;
                        result_next = '0;
                    end
                end
                ST_RUN: begin
                    // Bank answers in the same cycle for the group currently presented.
                    result_next = set_nibble(result, idx, sbox_out);
                    if (idx == IDX_W'(NUM_BOX - 1)) begin
                        state_next = ST_DONE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next  = ST_IDLE;
                    idx_next    = '0;
                    data_next   = '0;
                    result_next = '0;
                end
            endcase
        end

        in_ready_next  = (state_next == ST_IDLE);
        busy_next      = (state_next == ST_RUN) || (state_next == ST_DONE);
        out_valid_next = (state_next == ST_DONE);
        out_data_next  = (state_next == ST_DONE) ? result_next : '0;
        sbox_sel_next  = (state_next == ST_RUN) ? idx_next : '0;
        sbox_in_next   = (state_next == ST_RUN) ? get_group(data_next, idx_next) : '0;
    end

    // Control state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            data_reg <= '0;
            result   <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            data_reg <= data_next;
            result   <= result_next;
        end
    end

    // Output registers, loaded with the decode of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sbox_sel  <= '0;
            sbox_in   <= '0;
        end else begin
            in_ready  <= in_ready_next;
            busy      <= busy_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            sbox_sel  <= sbox_sel_next;
            sbox_in   <= sbox_in_next;
        end
    end

endmodule

// File: tb/tb_sbox_round_sequencer.sv
// Directed bench for the S-box round sequencer with a stub or the real bank.
module tb_sbox_round_sequencer;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_out;
    logic [3:0]  bank_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        use_stub;
    logic        seen;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] STUB_A = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8};
    localparam logic [47:0] STUB_B = {6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16};

    always #5 clk = ~clk;

    sbox_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sbox_sel  (sbox_sel),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    sbox_bank u_bank (
        .sbox_sel   (sbox_sel),
        .sbox_in    (sbox_in),
        .sbox_out_c (bank_out)
    );

    assign sbox_out = use_stub ? sbox_in[3:0] : bank_out;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [47:0] d);
        check_eq("ready_before_accept", 48'(in_ready), 48'd1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        use_stub  = 1'b1;
        seen      = 1'b0;
        tick();
        tick();

        // Reset values
        check_eq("rst_in_ready",  48'(in_ready),  48'd1);
        check_eq("rst_out_valid", 48'(out_valid), 48'd0);
        check_eq("rst_out_data",  48'(out_data),  48'd0);
        check_eq("rst_busy",      48'(busy),      48'd0);
        check_eq("rst_sbox_sel",  48'(sbox_sel),  48'd0);
        check_eq("rst_sbox_in",   48'(sbox_in),   48'd0);
        rst = 1'b0;
        tick();

        // Stub bank: select steps 0..7, input changes during RUN are ignored
        accept(STUB_A);
        for (int k = 0; k < 8; k++) begin
            check_eq("run_sbox_sel",  48'(sbox_sel),  48'(k));
            check_eq("run_sbox_in",   48'(sbox_in),   48'(k + 1));
            check_eq("run_out_valid", 48'(out_valid), 48'd0);
            check_eq("run_in_ready",  48'(in_ready),  48'd0);
            if (k == 0) in_data = 48'hFFFF_FFFF_FFFF;
            tick();
        end
        check_eq("stub_out_valid", 48'(out_valid), 48'd1);
        check_eq("stub_out_data",  48'(out_data),  48'h1234_5678);
        check_eq("done_busy",      48'(busy),      48'd1);
        check_eq("done_sbox_sel",  48'(sbox_sel),  48'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("hs_out_valid", 48'(out_valid), 48'd0);
        check_eq("hs_in_ready",  48'(in_ready),  48'd1);
        check_eq("hs_out_data",  48'(out_data),  48'd0);

        // Real bank: row 0 col 0 and row 3 col 15 of every box
        use_stub  = 1'b0;
        out_ready = 1'b1;
        accept(48'h0);
        repeat (7) tick();
        check_eq("real_not_early", 48'(out_valid), 48'd0);
        tick();
        check_eq("real0_out_valid", 48'(out_valid), 48'd1);
        check_eq("real0_out_data",  48'(out_data),  48'hEFA7_2C4D);
        tick();
        accept(48'hFFFF_FFFF_FFFF);
        repeat (8) tick();
        check_eq("real1_out_data", 48'(out_data), 48'hD9CE_3DCB);
        tick();
        out_ready = 1'b0;

        // Back-pressure for 20 cycles with a competing input offered
        use_stub = 1'b1;
        accept(STUB_A);
        repeat (8) tick();
        in_valid = 1'b1;
        in_data  = 48'hABCD_EF01_2345;
        for (int k = 0; k < 20; k++) begin
            check_eq("bp_out_valid", 48'(out_valid), 48'd1);
            check_eq("bp_out_data",  48'(out_data),  48'h1234_5678);
            check_eq("bp_in_ready",  48'(in_ready),  48'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_rel_in_ready",  48'(in_ready),  48'd1);
        check_eq("bp_rel_out_valid", 48'(out_valid), 48'd0);
        check_eq("bp_rel_busy",      48'(busy),      48'd0);

        // Abort at idx 3, then a fresh transaction with no residue
        accept(STUB_A);
        repeat (3) tick();
        check_eq("ab_sel3", 48'(sbox_sel), 48'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("ab_busy",      48'(busy),      48'd0);
        check_eq("ab_in_ready",  48'(in_ready),  48'd1);
        check_eq("ab_sbox_sel",  48'(sbox_sel),  48'd0);
        check_eq("ab_out_valid", 48'(out_valid), 48'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_eq("ab_never_valid", 48'(seen), 48'd0);
        accept(STUB_B);
        repeat (8) tick();
        check_eq("ab_fresh_valid", 48'(out_valid), 48'd1);
        check_eq("ab_fresh_data",  48'(out_data),  48'h9ABC_DEF0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Async reset between edges in RUN
        use_stub = 1'b0;
        accept(STUB_A);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_in_ready",  48'(in_ready),  48'd1);
        check_eq("mrst_busy",      48'(busy),      48'd0);
        check_eq("mrst_sbox_sel",  48'(sbox_sel),  48'd0);
        check_eq("mrst_sbox_in",   48'(sbox_in),   48'd0);
        check_eq("mrst_out_valid", 48'(out_valid), 48'd0);
        check_eq("mrst_out_data",  48'(out_data),  48'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        accept(48'h0);
        repeat (8) tick();
        check_eq("mrst_after_data", 48'(out_data), 48'hEFA7_2C4D);
        tick();
        out_ready = 1'b0;

        // abort wins over in_valid in IDLE
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = STUB_A;
        tick();
        check_eq("abiv_busy",     48'(busy),     48'd0);
        check_eq("abiv_in_ready", 48'(in_ready), 48'd1);
        check_eq("abiv_sbox_sel", 48'(sbox_sel), 48'd0);
        abort    = 1'b0;
        in_valid = 1'b0;
        tick();
        check_eq("abiv_still_idle", 48'(busy), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox_round_sequencer.md
Name: sbox_round_sequencer

Overview:
- Time-multiplexes one shared DES S-box lookup path over the 8 six-bit groups of a 48-bit round value (E-expansion XOR subkey).
- Produces the 32-bit substitution result, one group per clock.
- Sits between the round key-mix stage and the P-permutation stage.
- Drives an external `sbox_bank` (S1..S8 mux) through a select/data/return port trio.

Parameters:
- NUM_BOX, 8, number of S-boxes/groups sequenced.
- SB_IN_W, 6, S-box input width.
- SB_OUT_W, 4, S-box output width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- abort  in  1  synchronous flush, active-high
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data
- in_data  in  48  round value; group k = bits [47-6k -: 6]
- sbox_sel  out  3  S-box index to bank (0=S1 .. 7=S8)
- sbox_in  out  6  raw 6-bit group to bank; row/column decode stays inside the S-box
- sbox_out  in  4  bank result, combinational from sbox_sel/sbox_in, same cycle
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  32  result; S(k) output at bits [31-4k -: 4]
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset: one clock; async active-high reset.
  - On rst: state=IDLE, idx=0, data_reg=0, result=0.
  - Output values: out_valid=0, out_data=0, busy=0, sbox_sel=0, sbox_in=0, in_ready=1.
- States: IDLE, RUN, DONE; 2-bit encoding, values in package.
- IDLE:
  - in_ready=1; sbox_sel=0, sbox_in=0.
  - On in_valid at an edge: latch in_data into data_reg, clear result, idx=0, go to RUN.
- RUN (8 cycles):
  - in_ready=0; sbox_sel=idx; sbox_in=data_reg[47-6*idx -: 6].
  - Each edge: result[31-4*idx -: 4] <= sbox_out.
  - If idx==7: go to DONE, idx=0. Otherwise idx=idx+1.
  - idx is 3 bits; never wraps inside RUN.
- DONE:
  - out_valid=1; out_data=result, stable until the handshake.
  - in_ready=0; sbox_sel=0, sbox_in=0.
  - On out_ready: go to IDLE; out_valid falls at that edge.
- out_data: driven from result in DONE; 0 otherwise.
- Latency:
  - Accept edge E0; results captured at E1..E8.
  - out_valid high from just after E8, i.e. 8 clocks after accept.
  - Minimum spacing between accepts: 10 clocks.
  - in_ready is not raised in DONE; there is one IDLE bubble.
- abort:
  - Any state, next edge: IDLE, idx=0, result=0, data_reg=0.
  - Has priority over in_valid in IDLE and out_ready in DONE. abort with in_valid in IDLE: input dropped.
- Back-pressure: out_ready low in DONE holds out_data indefinitely; in_valid ignored meanwhile.
- in_data changes in RUN: ignored; only the latched data_reg is used.
- Mid-operation rst: immediate return to reset values; partial result discarded.
- No X on outputs: all outputs are driven in every state.

Decomposition:
- Package des_pkg holds:
  - constants NUM_BOX=8, SB_IN_W=6, SB_OUT_W=4, BLK_IN_W=48, BLK_OUT_W=32;
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- Sub-module `sbox_bank`:
  - Combinational; instantiates S1..S8 and muxes them on sbox_sel.
  - Instantiated beside this controller by the round module, not inside it.
  - Keeps the controller bank-agnostic and testable with a stub.

Test Plan:
- Stub bank (sbox_out=sbox_in[3:0]); in_data has groups 6'd1..6'd8 (group 0 = 6'd1 at bits 47:42); pulse in_valid.
  - Required: sbox_sel steps 0..7 on consecutive cycles.
  - Required: out_valid 8 clocks after accept, out_data=32'h12345678.
- Real `sbox_bank`, in_data=48'h0, out_ready=1.
  - Required: out_data=32'hEFA72C4D (S1..S8 row0 col0 = 14,15,10,7,2,12,4,13).
- out_ready held low 20 cycles in DONE.
  - Required: out_valid and out_data stable, in_ready=0, second in_valid not accepted.
  - On releasing out_ready: IDLE next cycle, in_ready=1.
- abort asserted at RUN idx=3.
  - Required: IDLE next edge, out_valid never asserts.
  - Required: a following fresh transaction returns the correct result with no residue.
- rst asserted mid-RUN (async, between edges).
  - Required: outputs immediately at reset values.
  - Required: after release, all-zero input gives 32'hEFA72C4D.
- abort and in_valid high together in IDLE.
  - Required: no accept, state remains IDLE, busy=0.
